// File: rtl/board_feeder_if.sv
// Bundle of the load, board-issue, attack-reply and result signals around board_feeder.
// The master modport is the feeder's view. The slave modport is the host/array environment.
interface board_feeder_if #(
   parameter int PIECE_WIDTH = 4,
   parameter int BOARD_WIDTH = 256
);
   logic                   load_clear;
   logic                   sq_wr_valid;
   logic [5:0]             sq_index;
   logic [PIECE_WIDTH-1:0] sq_piece;
   logic                   load_commit;
   logic                   commit_wtm;
   logic                   load_ready;
   logic [BOARD_WIDTH-1:0] board;
   logic                   board_valid;
   logic                   white_to_move;
   logic [63:0]            attacked_white;
   logic [63:0]            attacked_white_valid;
   logic [63:0]            attacked_black;
   logic [63:0]            attacked_black_valid;
   logic                   result_valid;
   logic                   result_ready;
   logic [63:0]            result_white;
   logic [63:0]            result_black;
   logic                   result_timeout;

   modport master (
      input  load_clear, sq_wr_valid, sq_index, sq_piece, load_commit, commit_wtm,
      input  attacked_white, attacked_white_valid, attacked_black, attacked_black_valid,
      input  result_ready,
      output load_ready, board, board_valid, white_to_move,
      output result_valid, result_white, result_black, result_timeout
   );

   modport slave (
      output load_clear, sq_wr_valid, sq_index, sq_piece, load_commit, commit_wtm,
      output attacked_white, attacked_white_valid, attacked_black, attacked_black_valid,
      output result_ready,
      input  load_ready, board, board_valid, white_to_move,
      input  result_valid, result_white, result_black, result_timeout
   );
endinterface

// File: rtl/board_feeder.sv
// Builds a shadow board from square writes and issues it with a one-cycle board_valid pulse.
// Collects the sticky per-square attack replies and returns them through a valid/ready result port.
module board_feeder #(
   parameter int PIECE_WIDTH    = 4,
   parameter int SIDE_WIDTH     = 1,
   parameter int BOARD_WIDTH    = 256,
   parameter int TIMEOUT_CYCLES = 64
) (
   input logic            clk,
   input logic            reset,
   board_feeder_if.master bus
);

   if (BOARD_WIDTH != 64*PIECE_WIDTH || SIDE_WIDTH > PIECE_WIDTH ||
       TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 128) begin : g_bad_cfg
      $error("board_feeder: inconsistent parameter set");
   end

   localparam logic [6:0] LAST_WAIT = 7'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_LOAD, S_ISSUE, S_WAIT, S_RESULT} state_t;

   state_t                 state, state_nxt;
   logic [BOARD_WIDTH-1:0] board_q, board_nxt;
   logic                   wtm_q;
   logic [63:0]            acc_w, acc_b, res_w, res_b;
   logic [63:0]            acc_w_nxt, acc_b_nxt;
   logic                   res_to;
   logic [6:0]             wait_cnt;
   logic                   all_seen, timed_out;

   // Completion counts the replies arriving in this very cycle.
   assign acc_w_nxt = acc_w | bus.attacked_white_valid;
   assign acc_b_nxt = acc_b | bus.attacked_black_valid;
   assign all_seen  = (&acc_w_nxt) & (&acc_b_nxt);
   assign timed_out = (wait_cnt == LAST_WAIT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_LOAD;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt        = state;
      bus.load_ready   = 1'b0;
      bus.board_valid  = 1'b0;
      bus.result_valid = 1'b0;
      case (state)
         S_LOAD: begin
            bus.load_ready = 1'b1;
            if (bus.load_commit) state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            bus.board_valid = 1'b1;
            state_nxt       = S_WAIT;
         end
         S_WAIT: begin
            if (all_seen || timed_out) state_nxt = S_RESULT;
         end
         S_RESULT: begin
            bus.result_valid = 1'b1;
            if (bus.result_ready) state_nxt = S_LOAD;
         end
         default: state_nxt = S_LOAD;
      endcase
   end

   // Clear is applied first so a write in the same cycle survives it.
   always_comb begin
      board_nxt = board_q;
      if (bus.load_clear) board_nxt = '0;
      if (bus.sq_wr_valid)
         board_nxt[int'(bus.sq_index)*PIECE_WIDTH +: PIECE_WIDTH] = bus.sq_piece;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         board_q  <= '0;
         wtm_q    <= 1'b0;
         acc_w    <= '0;
         acc_b    <= '0;
         res_w    <= '0;
         res_b    <= '0;
         res_to   <= 1'b0;
         wait_cnt <= '0;
      end else begin
         case (state)
            S_LOAD: begin
               board_q <= board_nxt;
               if (bus.load_commit) wtm_q <= bus.commit_wtm;
            end
            S_ISSUE: begin
               acc_w    <= '0;
               acc_b    <= '0;
               res_w    <= '0;
               res_b    <= '0;
               wait_cnt <= '0;
            end
            S_WAIT: begin
               acc_w <= acc_w_nxt;
               acc_b <= acc_b_nxt;
               res_w <= res_w | (bus.attacked_white & bus.attacked_white_valid & ~acc_w);
               res_b <= res_b | (bus.attacked_black & bus.attacked_black_valid & ~acc_b);
               if (wait_cnt != 7'h7F) wait_cnt <= wait_cnt + 7'd1;
               if (all_seen || timed_out) res_to <= ~all_seen;
            end
            default: ;
         endcase
      end
   end

   assign bus.board          = board_q;
   assign bus.white_to_move  = wtm_q;
   assign bus.result_white   = res_w;
   assign bus.result_black   = res_b;
   assign bus.result_timeout = res_to;

endmodule

// File: tb/tb_board_feeder.sv
// Bench for board_feeder: load-cycle vector table, directed corner sequences,
// and randomized transactions checked against a square-array / arrival-time model.
module tb_board_feeder;
   localparam int T = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   board_feeder_if #(.PIECE_WIDTH(4), .BOARD_WIDTH(256)) bus ();

   board_feeder #(
      .PIECE_WIDTH(4), .SIDE_WIDTH(1), .BOARD_WIDTH(256), .TIMEOUT_CYCLES(T)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   int checks = 0;
   int failures = 0;

   logic [3:0]  shadow [64];
   logic        model_wtm;
   int          arr_w [64];
   int          arr_b [64];
   logic [63:0] val_w, val_b;

   typedef struct {
      logic       clr;
      logic       wr;
      logic [5:0] idx;
      logic [3:0] piece;
      logic [5:0] pidx;
      logic [3:0] exp;
   } vec_t;
   vec_t tbl [10];

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk(name, 256'(act), 256'(exp));
   endtask

   task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk(name, 256'(act), 256'(exp));
   endtask

   function automatic logic [255:0] model_board();
      logic [255:0] b;
      for (int i = 0; i < 64; i++) b[i*4 +: 4] = shadow[i];
      return b;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_load();
      bus.load_clear  = 1'b0;
      bus.sq_wr_valid = 1'b0;
      bus.sq_index    = '0;
      bus.sq_piece    = '0;
      bus.load_commit = 1'b0;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 64; i++) shadow[i] = 4'h0;
   endtask

   // One LOAD cycle of clear/write; the model applies clear then write.
   task automatic load_cycle(input logic clr, input logic wr, input logic [5:0] idx, input logic [3:0] pc);
      chk1("load_ready_in_load", bus.load_ready, 1'b1);
      bus.load_clear  = clr;
      bus.sq_wr_valid = wr;
      bus.sq_index    = idx;
      bus.sq_piece    = pc;
      tick();
      idle_load();
      if (clr) model_clear();
      if (wr) shadow[idx] = pc;
   endtask

   // Reply stream for WAIT cycle k: silent before arrival, true value at arrival, inverted noise after.
   task automatic drive_reply(input int k);
      for (int i = 0; i < 64; i++) begin
         if (k < arr_w[i]) begin
            bus.attacked_white_valid[i] = 1'b0;
            bus.attacked_white[i]       = 1'($urandom);
         end else if (k == arr_w[i]) begin
            bus.attacked_white_valid[i] = 1'b1;
            bus.attacked_white[i]       = val_w[i];
         end else begin
            bus.attacked_white_valid[i] = 1'($urandom);
            bus.attacked_white[i]       = ~val_w[i];
         end
         if (k < arr_b[i]) begin
            bus.attacked_black_valid[i] = 1'b0;
            bus.attacked_black[i]       = 1'($urandom);
         end else if (k == arr_b[i]) begin
            bus.attacked_black_valid[i] = 1'b1;
            bus.attacked_black[i]       = val_b[i];
         end else begin
            bus.attacked_black_valid[i] = 1'($urandom);
            bus.attacked_black[i]       = ~val_b[i];
         end
      end
   endtask

   task automatic txn(input logic wtm, input int ready_delay, input logic poke);
      int           last, fin;
      logic         tout;
      logic [63:0]  ew, eb;
      logic [255:0] bexp;
      last = 0;
      for (int i = 0; i < 64; i++) begin
         if (arr_w[i] > last) last = arr_w[i];
         if (arr_b[i] > last) last = arr_b[i];
      end
      tout = (last > T);
      fin  = tout ? T : last;
      for (int i = 0; i < 64; i++) begin
         ew[i] = (arr_w[i] <= fin) ? val_w[i] : 1'b0;
         eb[i] = (arr_b[i] <= fin) ? val_b[i] : 1'b0;
      end
      bexp = model_board();

      chk1("load_ready_pre_commit", bus.load_ready, 1'b1);
      bus.load_commit = 1'b1;
      bus.commit_wtm  = wtm;
      chk1("board_valid_commit_cycle", bus.board_valid, 1'b0);
      tick();
      bus.load_commit = 1'b0;
      bus.commit_wtm  = 1'($urandom);
      model_wtm       = wtm;
      chk1("board_valid_issue", bus.board_valid, 1'b1);
      chk1("load_ready_issue", bus.load_ready, 1'b0);
      chk1("white_to_move", bus.white_to_move, model_wtm);
      chk("board_issue", bus.board, bexp);
      bus.attacked_white_valid = {$urandom, $urandom};
      bus.attacked_black_valid = {$urandom, $urandom};
      bus.attacked_white       = {$urandom, $urandom};
      bus.attacked_black       = {$urandom, $urandom};

      for (int k = 1; k <= fin + 1; k++) begin
         tick();
         chk1("result_valid_timing", bus.result_valid, k == fin + 1);
         chk1("board_valid_after_issue", bus.board_valid, 1'b0);
         if (k <= fin) begin
            drive_reply(k);
            bus.result_ready = 1'($urandom);
            if (poke && k == 1) begin
               bus.load_clear  = 1'b1;
               bus.sq_wr_valid = 1'b1;
               bus.sq_index    = 6'($urandom);
               bus.sq_piece    = 4'($urandom);
               bus.load_commit = 1'b1;
            end else begin
               idle_load();
            end
         end
      end
      bus.result_ready = 1'b0;
      idle_load();
      chk64("result_white", bus.result_white, ew);
      chk64("result_black", bus.result_black, eb);
      chk1("result_timeout", bus.result_timeout, tout);
      chk("board_stable_wait", bus.board, bexp);
      chk1("load_ready_result", bus.load_ready, 1'b0);

      for (int d = 0; d < ready_delay; d++) begin
         bus.attacked_white_valid = {$urandom, $urandom};
         bus.attacked_white       = {$urandom, $urandom};
         tick();
         chk1("result_valid_hold", bus.result_valid, 1'b1);
         chk64("result_white_hold", bus.result_white, ew);
      end
      bus.result_ready = 1'b1;
      tick();
      bus.result_ready = 1'b0;
      chk1("result_valid_drop", bus.result_valid, 1'b0);
      chk1("load_ready_back", bus.load_ready, 1'b1);
      chk("board_after_result", bus.board, bexp);
   endtask

   task automatic set_arrivals(input int a);
      for (int i = 0; i < 64; i++) begin
         arr_w[i] = a;
         arr_b[i] = a;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "bench time limit");
   end

   initial begin
      tbl[0] = '{1'b0, 1'b1, 6'd4,  4'h6, 6'd4,  4'h6};
      tbl[1] = '{1'b0, 1'b1, 6'd60, 4'hE, 6'd60, 4'hE};
      tbl[2] = '{1'b0, 1'b1, 6'd4,  4'h3, 6'd4,  4'h3};
      tbl[3] = '{1'b1, 1'b1, 6'd9,  4'h5, 6'd9,  4'h5};
      tbl[4] = '{1'b0, 1'b0, 6'd0,  4'h0, 6'd4,  4'h0};
      tbl[5] = '{1'b0, 1'b0, 6'd0,  4'h0, 6'd60, 4'h0};
      tbl[6] = '{1'b0, 1'b1, 6'd63, 4'hF, 6'd63, 4'hF};
      tbl[7] = '{1'b0, 1'b1, 6'd0,  4'h1, 6'd0,  4'h1};
      tbl[8] = '{1'b1, 1'b0, 6'd0,  4'h0, 6'd63, 4'h0};
      tbl[9] = '{1'b0, 1'b1, 6'd4,  4'h6, 6'd4,  4'h6};

      reset = 1'b0;
      idle_load();
      bus.commit_wtm           = 1'b0;
      bus.result_ready         = 1'b0;
      bus.attacked_white       = '0;
      bus.attacked_white_valid = '0;
      bus.attacked_black       = '0;
      bus.attacked_black_valid = '0;
      model_clear();
      model_wtm = 1'b0;
      set_arrivals(1);
      val_w = '0;
      val_b = '0;

      // Reset values
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b1;
      tick();
      chk1("reset_load_ready", bus.load_ready, 1'b1);
      chk("reset_board", bus.board, 256'd0);
      chk1("reset_board_valid", bus.board_valid, 1'b0);
      chk1("reset_result_valid", bus.result_valid, 1'b0);
      chk1("reset_wtm", bus.white_to_move, 1'b0);
      chk1("reset_timeout", bus.result_timeout, 1'b0);
      chk64("reset_result_white", bus.result_white, 64'd0);

      // Load-cycle vector table
      for (int i = 0; i < 10; i++) begin
         load_cycle(tbl[i].clr, tbl[i].wr, tbl[i].idx, tbl[i].piece);
         chk("tbl_square", 256'(bus.board[int'(tbl[i].pidx)*4 +: 4]), 256'(tbl[i].exp));
      end

      // Clear and write in the same cycle leave only the written square
      load_cycle(1'b1, 1'b1, 6'd9, 4'h5);
      chk("clear_write_same_cycle", bus.board, 256'h5 << 36);

      // Load and full reply on the third WAIT cycle
      load_cycle(1'b1, 1'b0, 6'd0, 4'h0);
      load_cycle(1'b0, 1'b1, 6'd4, 4'h6);
      load_cycle(1'b0, 1'b1, 6'd60, 4'hE);
      chk("board_sq4", 256'(bus.board[19:16]), 256'h6);
      chk("board_sq60", 256'(bus.board[243:240]), 256'hE);
      set_arrivals(3);
      val_w = 64'h00FF;
      val_b = 64'h8000_0000_0000_0001;
      txn(1'b1, 2, 1'b1);

      // Sticky capture on square 0
      set_arrivals(4);
      arr_w[0] = 1;
      val_w = 64'h1;
      val_b = {$urandom, $urandom};
      txn(1'b0, 1, 1'b1);

      // Timeout with one reply missing
      set_arrivals(2);
      arr_b[37] = 99;
      val_w = {$urandom, $urandom};
      val_b = {$urandom, $urandom} | (64'h1 << 37);
      txn(1'b1, 0, 1'b0);

      // Reset during WAIT discards the pending result and empties the board
      load_cycle(1'b0, 1'b1, 6'd12, 4'h7);
      set_arrivals(99);
      bus.load_commit = 1'b1;
      bus.commit_wtm  = 1'b1;
      tick();
      bus.load_commit = 1'b0;
      tick();
      drive_reply(1);
      tick();
      #2;
      reset = 1'b0;
      #1;
      chk("async_reset_board", bus.board, 256'd0);
      chk1("async_reset_load_ready", bus.load_ready, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      model_clear();
      model_wtm = 1'b0;
      bus.attacked_white_valid = '0;
      bus.attacked_black_valid = '0;
      tick();
      chk1("midwait_reset_load_ready", bus.load_ready, 1'b1);
      chk("midwait_reset_board", bus.board, 256'd0);
      chk1("midwait_reset_wtm", bus.white_to_move, 1'b0);
      for (int c = 0; c < T + 4; c++) begin
         tick();
         chk1("midwait_no_result", bus.result_valid, 1'b0);
      end

      // Randomized transactions
      for (int t = 0; t < 24; t++) begin
         int nl;
         nl = int'($urandom_range(0, 6));
         for (int j = 0; j < nl; j++)
            load_cycle($urandom_range(0, 7) == 0, 1'($urandom), 6'($urandom), 4'($urandom));
         for (int i = 0; i < 64; i++) begin
            arr_w[i] = int'($urandom_range(1, 5));
            arr_b[i] = int'($urandom_range(1, 5));
         end
         if ($urandom_range(0, 3) == 0) arr_w[$urandom_range(0, 63)] = 99;
         val_w = {$urandom, $urandom};
         val_b = {$urandom, $urandom};
         txn(1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
         chk("random_board_model", bus.board, model_board());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
